// File: rtl/cmem_refill_arb_pkg.sv
// Shared types and defaults for the cmem line-refill arbiter.
package cmem_refill_arb_pkg;
  localparam int CMEM_BLK_LEN   = 26;
  localparam int CMEM_LINE      = 128;
  localparam int CMEM_ARB_N_REQ = 2;

  typedef enum logic [1:0] {
    S_ARB_IDLE = 2'd0,
    S_ARB_BUSY = 2'd1,
    S_ARB_DONE = 2'd2
  } arb_state_e;

  // a is at most 2n-2, so a single subtract is enough to wrap
  function automatic int rr_wrap(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction
endpackage

// File: rtl/cmem_refill_arb_if.sv
// Bus bundle between the cmem array, the refill arbiter and the memory adapter.
interface cmem_refill_arb_if
  import cmem_refill_arb_pkg::*;
#(
  parameter int N_REQ  = CMEM_ARB_N_REQ,
  parameter int ADDR_W = CMEM_BLK_LEN,
  parameter int LINE_W = CMEM_LINE,
  localparam int GNT_W = $clog2(N_REQ)
) ();
  logic [N_REQ*ADDR_W-1:0] b_addr_c;
  logic [N_REQ-1:0]        b_rd_c;
  logic [LINE_W-1:0]       b_rdata_c;
  logic [N_REQ-1:0]        b_dv_c;
  logic [ADDR_W-1:0]       m_addr;
  logic                    m_rd;
  logic [LINE_W-1:0]       m_rdata;
  logic                    m_dv;
  logic [GNT_W-1:0]        gnt_idx;
  logic                    busy;

  modport slave (
    input  b_addr_c, b_rd_c, m_rdata, m_dv,
    output b_rdata_c, b_dv_c, m_addr, m_rd, gnt_idx, busy
  );
  modport master (
    output b_addr_c, b_rd_c, m_rdata, m_dv,
    input  b_rdata_c, b_dv_c, m_addr, m_rd, gnt_idx, busy
  );
endinterface

// File: rtl/cmem_refill_arb_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
module cmem_refill_arb_rr_pick
  import cmem_refill_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int GNT_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [GNT_W-1:0] ptr,
  output logic [GNT_W-1:0] idx,
  output logic             any
);
  logic [GNT_W-1:0] cand;

  // scan farthest-first so the closest hit to ptr is the one left standing
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = GNT_W'(rr_wrap(int'(ptr) + k, N));
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cmem_refill_arb.sv
// Multiplexes N cmem refill buses onto one memory port, one refill in flight, rr grant.
module cmem_refill_arb
  import cmem_refill_arb_pkg::*;
#(
  parameter int N_REQ  = CMEM_ARB_N_REQ,
  parameter int ADDR_W = CMEM_BLK_LEN,
  parameter int LINE_W = CMEM_LINE,
  localparam int GNT_W = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               rst,
  cmem_refill_arb_if.slave  bus
);
  arb_state_e        state_q, state_d;
  logic [GNT_W-1:0]  gnt_q, gnt_d, ptr_q, ptr_d, pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0]  dv_q, dv_d;

  cmem_refill_arb_rr_pick #(.N(N_REQ)) u_pick (
    .req (bus.b_rd_c),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    dv_d    = '0;
    case (state_q)
      S_ARB_IDLE: if (pick_any) begin
        gnt_d   = pick_idx;
        addr_d  = bus.b_addr_c[pick_idx*ADDR_W +: ADDR_W];
        state_d = S_ARB_BUSY;
      end
      // a grantee that withdrew still lets the read finish; its line is just dropped
      S_ARB_BUSY: if (bus.m_dv) begin
        rdata_d      = bus.m_rdata;
        dv_d[gnt_q]  = bus.b_rd_c[gnt_q];
        state_d      = S_ARB_DONE;
      end
      S_ARB_DONE: begin
        ptr_d   = (gnt_q == GNT_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = S_ARB_IDLE;
      end
      default: state_d = S_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      dv_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      dv_q    <= dv_d;
    end
  end

  assign bus.m_rd      = (state_q == S_ARB_BUSY);
  assign bus.m_addr    = addr_q;
  assign bus.b_rdata_c = rdata_q;
  assign bus.b_dv_c    = dv_q;
  assign bus.gnt_idx   = gnt_q;
  assign bus.busy      = (state_q != S_ARB_IDLE);
endmodule
